// File: rtl/bcd_pkg.sv
// Shared BCD constants, converter state encoding and digit helper
// for the forward and reverse BCD conversion blocks.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT     = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_ADJ_THRESH_DN = 4'd8;
  localparam logic [DIGIT_W-1:0] BCD_ADJ_VAL       = 4'd3;
  localparam logic [DIGIT_W-1:0] BCD_ADJ_THRESH_UP = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    ERRD  = 2'd3
  } state_t;

  function automatic logic digit_is_bcd(input logic [DIGIT_W-1:0] d);
    return (d <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Start/done handshake and data bus of the sequential BCD-to-binary converter.
interface bcd2bin_seq_if
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BINW   = 10
);

  logic                        start;
  logic [DIGIT_W*DIGITS-1:0]   bcd_in;
  logic                        ready;
  logic                        busy;
  logic                        done;
  logic                        err;
  logic [BINW-1:0]             bin_out;

  modport master (
    output start, bcd_in,
    input  ready, busy, done, err, bin_out
  );

  modport slave (
    input  start, bcd_in,
    output ready, busy, done, err, bin_out
  );

endinterface

// File: rtl/bcd_digit_adj_dn.sv
// Reverse double-dabble digit cell: subtract 3 when the digit is 8 or more.
module bcd_digit_adj_dn
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  // d >= 8 means the subtraction never underflows
  assign q = (d >= BCD_ADJ_THRESH_DN) ? (d - BCD_ADJ_VAL) : d;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one right shift plus per-digit
// subtract-3 correction per clock, BINW clocks per conversion.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BINW   = 10
)(
  input  logic        clk,
  input  logic        rst,
  bcd2bin_seq_if.slave bus
);

  localparam int unsigned BCDW  = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = (BINW > 1) ? $clog2(BINW) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BINW - 1);

  state_t             state_q, state_d;
  logic [BCDW-1:0]    bcd_q, bcd_d;
  logic [BINW-1:0]    bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BINW-1:0]    bin_out_q, bin_out_d;
  logic               err_q, err_d;

  logic [BCDW+BINW-1:0] sh_all;
  logic [BCDW-1:0]      sh_bcd;
  logic [BINW-1:0]      sh_bin;
  logic [BCDW-1:0]      adj_bcd;
  logic                 in_valid;

  // The BCD LSB falls into the binary MSB as one concatenated shift
  assign sh_all = {bcd_q, bin_q} >> 1;
  assign sh_bcd = sh_all[BCDW+BINW-1:BINW];
  assign sh_bin = sh_all[BINW-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj_dn u_adj (
      .d (sh_bcd [g*DIGIT_W +: DIGIT_W]),
      .q (adj_bcd[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    in_valid = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!digit_is_bcd(bus.bcd_in[i*DIGIT_W +: DIGIT_W])) in_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    cnt_d       = cnt_q;
    bin_out_d   = bin_out_q;
    err_d       = err_q;
    bus.ready   = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.err     = err_q;
    bus.bin_out = bin_out_q;

    case (state_q)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          bcd_d = bus.bcd_in;
          bin_d = '0;
          cnt_d = '0;
          err_d = 1'b0;
          if (in_valid) begin
            state_d = SHIFT;
          end else begin
            // Invalid operand: result is forced to zero for the error pulse
            state_d   = ERRD;
            err_d     = 1'b1;
            bin_out_d = '0;
          end
        end
      end
      SHIFT: begin
        bus.busy = 1'b1;
        bcd_d    = adj_bcd;
        bin_d    = sh_bin;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          bin_out_d = sh_bin;
          state_d   = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      ERRD: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every decimal weight must have been fully consumed by the last step
  a_bcd_drained: assert property (
    @(posedge clk) disable iff (rst) (state_q == DONE) |-> (bcd_q == '0)
  );

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: directed handshake cases, random and
// exhaustive sweeps against an arithmetic BCD reference model.
module tb_bcd2bin_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd2bin_seq_if #(.DIGITS(3), .BINW(10)) bus_a ();
  bcd2bin_seq_if #(.DIGITS(2), .BINW(7))  bus_b ();

  bcd2bin_seq #(.DIGITS(3), .BINW(10)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  bcd2bin_seq #(.DIGITS(2), .BINW(7))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Decimal value of nd packed BCD digits; any digit above 9 flags bad and yields 0
  function automatic void ref_bcd(input logic [15:0] b, input int nd,
                                  output int val, output bit bad);
    int weight = 1;
    logic [3:0] d;
    val = 0;
    bad = 1'b0;
    for (int i = 0; i < nd; i++) begin
      d = b[i*4 +: 4];
      if (d > 4'd9) bad = 1'b1;
      val += int'(d) * weight;
      weight *= 10;
    end
    if (bad) val = 0;
  endfunction

  function automatic logic [11:0] to_bcd3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic run_a(input logic [11:0] b);
    int n;
    int val;
    bit bad;
    ref_bcd({4'h0, b}, 3, val, bad);
    n = 0;
    while (!bus_a.ready && n < 30) begin @(negedge clk); n++; end
    check("a_ready_wait", 32'(bus_a.ready), 1);
    bus_a.bcd_in = b;
    bus_a.start  = 1'b1;
    @(negedge clk);
    bus_a.start  = 1'b0;
    bus_a.bcd_in = 12'($urandom);
    n = 0;
    if (!bad) check("a_busy", 32'(bus_a.busy), 1);
    while (!bus_a.done && n < 30) begin @(negedge clk); n++; end
    check("a_latency", 32'(n), bad ? 0 : 10);
    check("a_bin_out", 32'(bus_a.bin_out), 32'(val));
    check("a_err", 32'(bus_a.err), 32'(bad));
    @(negedge clk);
    check("a_done_pulse", 32'(bus_a.done), 0);
    check("a_ready_back", 32'(bus_a.ready), 1);
    check("a_err_held", 32'(bus_a.err), 32'(bad));
  endtask

  task automatic run_b(input logic [7:0] b);
    int n;
    int val;
    bit bad;
    ref_bcd({8'h00, b}, 2, val, bad);
    n = 0;
    while (!bus_b.ready && n < 30) begin @(negedge clk); n++; end
    bus_b.bcd_in = b;
    bus_b.start  = 1'b1;
    @(negedge clk);
    bus_b.start  = 1'b0;
    n = 0;
    while (!bus_b.done && n < 30) begin @(negedge clk); n++; end
    check("b_latency", 32'(n), bad ? 0 : 7);
    check("b_bin_out", 32'(bus_b.bin_out), 32'(val));
    check("b_err", 32'(bus_b.err), 32'(bad));
    @(negedge clk);
  endtask

  initial begin
    int n;
    int dones;
    logic [11:0] r;

    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.bcd_in = '0;
    bus_b.start = 1'b0; bus_b.bcd_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(bus_a.ready), 1);
    check("rst_busy", 32'(bus_a.busy), 0);
    check("rst_done", 32'(bus_a.done), 0);
    check("rst_err", 32'(bus_a.err), 0);
    check("rst_bin_out", 32'(bus_a.bin_out), 0);
    repeat (3) @(negedge clk);
    check("idle_no_start", 32'(bus_a.ready), 1);

    run_a(12'h999);
    run_a(12'h000);
    run_a(12'h255);
    run_a(12'h001);

    run_a(12'h0A5);
    repeat (3) @(negedge clk);
    check("err_still_held", 32'(bus_a.err), 1);
    check("err_bin_zero", 32'(bus_a.bin_out), 0);
    run_a(12'h059);

    // Starts during SHIFT and DONE must be dropped
    bus_a.bcd_in = 12'h999; bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    n = 0;
    while (!bus_a.done && n < 30) begin
      @(negedge clk); n++;
      if (n == 3) begin bus_a.start = 1'b1; bus_a.bcd_in = 12'h123; end
      else bus_a.start = 1'b0;
    end
    check("ign_latency", 32'(n), 10);
    check("ign_bin_out", 32'(bus_a.bin_out), 999);
    bus_a.start = 1'b1; bus_a.bcd_in = 12'h123;
    @(negedge clk);
    bus_a.start = 1'b0;
    check("ign_ready", 32'(bus_a.ready), 1);
    dones = 0;
    repeat (14) begin @(negedge clk); if (bus_a.done) dones++; end
    check("ign_no_extra_done", 32'(dones), 0);
    check("ign_bin_held", 32'(bus_a.bin_out), 999);

    // Reset in the middle of a conversion
    bus_a.bcd_in = 12'h456; bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", 32'(bus_a.ready), 1);
    check("mid_rst_busy", 32'(bus_a.busy), 0);
    check("mid_rst_done", 32'(bus_a.done), 0);
    check("mid_rst_bin_out", 32'(bus_a.bin_out), 0);
    dones = 0;
    repeat (15) begin @(negedge clk); if (bus_a.done) dones++; end
    check("mid_rst_no_done", 32'(dones), 0);
    run_a(12'h078);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 0) r = 12'($urandom);
      else r = to_bcd3(int'($urandom_range(0, 999)));
      run_a(r);
    end

    for (int v = 0; v < 1000; v++) run_a(to_bcd3(v));

    for (int v = 0; v < 100; v++) run_b({4'(v / 10), 4'(v % 10)});
    run_b(8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
